// File: rtl/alu_pkg.sv
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared constants and types for the bit-serial ALU sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_SUM  = 2'b10;
    localparam logic [1:0] OP_LESS = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } alu_state_t;

    typedef struct packed {
        logic       legal;
        logic       ainv;
        logic       binv;
        logic [1:0] op;
        logic       is_addsub;
        logic       is_slt;
    } alu_decode_t;

endpackage

`default_nettype wire

// File: rtl/alu_cell.sv
// ============================================================================
//  Module      : alu_cell
//  Description : One-bit ALU slice: optional operand inversion, AND/OR/SUM/LESS.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_cell
    import alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       a_invert,
    input  logic       b_invert,
    input  logic       carry_in,
    input  logic       less,
    input  logic [1:0] op,
    output logic       result,
    output logic       carry_out
);

    logic w_a;
    logic w_b;
    logic w_sum;

    assign w_a       = a ^ a_invert;
    assign w_b       = b ^ b_invert;
    assign w_sum     = w_a ^ w_b ^ carry_in;
    assign carry_out = (w_a & w_b) | (w_a & carry_in) | (w_b & carry_in);

    always_comb begin
        result = 1'b0;
        case (op)
            OP_AND:  result = w_a & w_b;
            OP_OR:   result = w_a | w_b;
            OP_SUM:  result = w_sum;
            default: result = less;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_serial_ctrl.sv
// ============================================================================
//  Module      : alu_serial_ctrl
//  Description : Bit-serial ALU sequencer driving one alu_cell LSB to MSB.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_serial_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       alu_ctl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal
);

    localparam int                c_idx_w    = $clog2(WIDTH);
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(WIDTH - 1);

    function automatic alu_decode_t decode_ctl(input logic [3:0] ctl);
        alu_decode_t d;
        d    = '0;
        d.op = OP_AND;
        case (ctl)
            ALU_AND: d.legal = 1'b1;
            ALU_OR:  begin d.legal = 1'b1; d.op = OP_OR; end
            ALU_ADD: begin d.legal = 1'b1; d.op = OP_SUM; d.is_addsub = 1'b1; end
            ALU_SUB: begin d.legal = 1'b1; d.binv = 1'b1; d.op = OP_SUM; d.is_addsub = 1'b1; end
            // SLT needs the full difference; the sum bits themselves are dropped
            ALU_SLT: begin d.legal = 1'b1; d.binv = 1'b1; d.op = OP_SUM; d.is_slt = 1'b1; end
            ALU_NOR: begin d.legal = 1'b1; d.ainv = 1'b1; d.binv = 1'b1; end
            default: ;
        endcase
        return d;
    endfunction

    alu_state_t         r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_shadow;
    logic [c_idx_w-1:0] r_idx;
    logic               r_carry;
    logic               r_ainv;
    logic               r_binv;
    logic [1:0]         r_op;
    logic               r_is_addsub;
    logic               r_is_slt;

    alu_decode_t        w_dec;
    logic               w_cell_res;
    logic               w_co;
    logic               w_ovf;
    logic               w_set;
    logic [WIDTH-1:0]   w_shadow_next;
    logic [WIDTH-1:0]   w_final;

    assign w_dec = decode_ctl(alu_ctl);

    alu_cell u_cell (
        .a         (r_a[r_idx]),
        .b         (r_b[r_idx]),
        .a_invert  (r_ainv),
        .b_invert  (r_binv),
        .carry_in  (r_carry),
        .less      (1'b0),
        .op        (r_op),
        .result    (w_cell_res),
        .carry_out (w_co)
    );

    // Only meaningful on the MSB cycle, which is the only time they are used
    assign w_ovf = r_carry ^ w_co;
    assign w_set = w_cell_res ^ w_ovf;

    always_comb begin
        w_shadow_next        = r_shadow;
        w_shadow_next[r_idx] = w_cell_res;
    end

    assign w_final = r_is_slt ? {{(WIDTH-1){1'b0}}, w_set} : w_shadow_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_shadow    <= '0;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_ainv      <= 1'b0;
            r_binv      <= 1'b0;
            r_op        <= OP_AND;
            r_is_addsub <= 1'b0;
            r_is_slt    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            zero        <= 1'b0;
            overflow    <= 1'b0;
            illegal     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    r_shadow <= w_shadow_next;
                    r_carry  <= w_co;
                    r_idx    <= r_idx + 1'b1;
                    if (r_idx == c_idx_last) begin
                        r_state  <= ST_DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        result   <= w_final;
                        zero     <= (w_final == '0);
                        overflow <= r_is_addsub & w_ovf;
                        illegal  <= 1'b0;
                    end
                end
                default: begin
                    if (start) begin
                        r_a         <= a;
                        r_b         <= b;
                        r_idx       <= '0;
                        r_carry     <= w_dec.binv;
                        r_ainv      <= w_dec.ainv;
                        r_binv      <= w_dec.binv;
                        r_op        <= w_dec.op;
                        r_is_addsub <= w_dec.is_addsub;
                        r_is_slt    <= w_dec.is_slt;
                        if (w_dec.legal) begin
                            r_state <= ST_RUN;
                            busy    <= 1'b1;
                        end else begin
                            r_state  <= ST_DONE;
                            done     <= 1'b1;
                            result   <= '0;
                            zero     <= 1'b1;
                            overflow <= 1'b0;
                            illegal  <= 1'b1;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_serial_ctrl.sv
// ============================================================================
//  Module      : tb_alu_serial_ctrl
//  Description : Scoreboard bench for the bit-serial ALU sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_serial_ctrl;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst;
    logic             start;
    logic [3:0]       alu_ctl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             illegal;

    alu_serial_ctrl #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .alu_ctl  (alu_ctl),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .zero     (zero),
        .overflow (overflow),
        .illegal  (illegal)
    );

    typedef struct {
        string            name;
        logic [WIDTH-1:0] res;
        logic             z;
        logic             ov;
        logic             il;
        int               due;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, req);
        end
    endtask

    // Monitor: every done must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_result"},   result,   e.res);
                check({e.name, "_zero"},     zero,     e.z);
                check({e.name, "_overflow"}, overflow, e.ov);
                check({e.name, "_illegal"},  illegal,  e.il);
                check({e.name, "_latency"},  cyc,      e.due);
            end
        end
    end

    // Called at a negedge; drives start for one cycle and ends at the next negedge
    task automatic issue(input string nm, input logic [3:0] ctl, input logic [WIDTH-1:0] va,
                         input logic [WIDTH-1:0] vb, input logic [WIDTH-1:0] res,
                         input logic z, input logic ov, input logic il, input bit push);
        exp_t e;
        start   = 1'b1;
        alu_ctl = ctl;
        a       = va;
        b       = vb;
        e.name = nm; e.res = res; e.z = z; e.ov = ov; e.il = il;
        e.due  = cyc + (il ? 1 : WIDTH + 1);
        if (push) sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int k;
        k = 0;
        while (done !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (done !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got no done, expected done within 100 cycles", nm);
        end
    endtask

    task automatic run_op(input string nm, input logic [3:0] ctl, input logic [WIDTH-1:0] va,
                          input logic [WIDTH-1:0] vb, input logic [WIDTH-1:0] res,
                          input logic z, input logic ov, input logic il);
        @(negedge clk);
        issue(nm, ctl, va, vb, res, z, ov, il, 1'b1);
        wait_done(nm);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; alu_ctl = 4'h0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy",   busy,   1'b0);
        check("reset_done",   done,   1'b0);
        check("reset_result", result, '0);
        check("reset_flags",  {zero, overflow, illegal}, 3'b000);

        run_op("add_ovf",  4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0);
        run_op("sub_zero", 4'b0110, 32'd5,        32'd5,        32'h00000000, 1'b1, 1'b0, 1'b0);
        run_op("sub_ovf",  4'b0110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0);
        run_op("slt_neg",  4'b0111, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0);
        run_op("slt_ovf",  4'b0111, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b1, 1'b0, 1'b0);
        run_op("or",       4'b0001, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 1'b0, 1'b0, 1'b0);

        // NOR then AND started in the NOR's done cycle
        run_op("nor", 4'b1100, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        issue("and_b2b", 4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_done("and_b2b");

        run_op("illegal", 4'b0101, 32'h12345678, 32'h9ABCDEF0, 32'h0, 1'b1, 1'b0, 1'b1);

        // A start while busy must not be accepted
        @(negedge clk);
        issue("add_busy", 4'b0010, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        check("busy_high", busy, 1'b1);
        start = 1'b1; alu_ctl = 4'b0110; a = 32'd100; b = 32'd1;
        @(negedge clk);
        start = 1'b0;
        wait_done("add_busy");

        // Asynchronous reset during bit 10 of an ADD
        @(negedge clk);
        issue("add_abort", 4'b0010, 32'hFFFF0000, 32'h0000FFFF, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy",   busy,   1'b0);
        check("abort_done",   done,   1'b0);
        check("abort_result", result, '0);
        check("abort_flags",  {zero, overflow, illegal}, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);

        run_op("add_after_rst", 4'b0010, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
